// File: rtl/rtoy_pkg.sv
// rtoy_pkg: shared RISC-TOY datapath widths and word/register-index types.
package rtoy_pkg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 2 ** AW;
    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] regaddr_t;
endpackage

// File: rtl/regfile_core.sv
// regfile_core: NREG x DW storage, one synchronous write port, two raw asynchronous read ports.
module regfile_core #(
    parameter int DW = rtoy_pkg::DW,
    parameter int AW = rtoy_pkg::AW,
    parameter int NREG = rtoy_pkg::NREG
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);
    logic [DW-1:0] regs [NREG];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, register file commit with write-first read bypass,
// and a wrapping count of committed register writes.
module wb_regfile #(
    parameter int DW = rtoy_pkg::DW,
    parameter int AW = rtoy_pkg::AW,
    parameter int NREG = rtoy_pkg::NREG
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          RegWrite_in,
    input  logic          MemtoReg_in,
    input  logic [AW-1:0] Write_Addr_in,
    input  logic [DW-1:0] Result_in,
    input  logic [DW-1:0] Read_data_in,
    input  logic [AW-1:0] Rd_Addr1,
    input  logic [AW-1:0] Rd_Addr2,
    output logic [DW-1:0] Rd_data1,
    output logic [DW-1:0] Rd_data2,
    output logic [DW-1:0] WB_value,
    output logic [31:0]   Retire_cnt
);
    logic [DW-1:0] raw1;
    logic [DW-1:0] raw2;

    regfile_core #(.DW(DW), .AW(AW), .NREG(NREG)) u_core (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .we     (RegWrite_in),
        .waddr  (Write_Addr_in),
        .wdata  (WB_value),
        .raddr1 (Rd_Addr1),
        .raddr2 (Rd_Addr2),
        .rdata1 (raw1),
        .rdata2 (raw2)
    );

    assign WB_value = MemtoReg_in ? Read_data_in : Result_in;
    // Bypass lets decode see this cycle's write without a stall.
    assign Rd_data1 = (RegWrite_in && Rd_Addr1 == Write_Addr_in) ? WB_value : raw1;
    assign Rd_data2 = (RegWrite_in && Rd_Addr2 == Write_Addr_in) ? WB_value : raw2;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) Retire_cnt <= '0;
        else if (RegWrite_in) Retire_cnt <= Retire_cnt + 32'd1;
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors with hand-computed expectations for wb_regfile.
module tb_wb_regfile;
    import rtoy_pkg::*;

    logic     CLK = 1'b0;
    logic     RSTN = 1'b0;
    logic     RegWrite_in = 1'b0;
    logic     MemtoReg_in = 1'b0;
    regaddr_t Write_Addr_in = '0;
    word_t    Result_in = '0;
    word_t    Read_data_in = '0;
    regaddr_t Rd_Addr1 = '0;
    regaddr_t Rd_Addr2 = '0;
    word_t    Rd_data1;
    word_t    Rd_data2;
    word_t    WB_value;
    logic [31:0] Retire_cnt;
    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .RegWrite_in   (RegWrite_in),
        .MemtoReg_in   (MemtoReg_in),
        .Write_Addr_in (Write_Addr_in),
        .Result_in     (Result_in),
        .Read_data_in  (Read_data_in),
        .Rd_Addr1      (Rd_Addr1),
        .Rd_Addr2      (Rd_Addr2),
        .Rd_data1      (Rd_data1),
        .Rd_data2      (Rd_data2),
        .WB_value      (WB_value),
        .Retire_cnt    (Retire_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < NREG; i++) begin
            Rd_Addr1 = regaddr_t'(i);
            Rd_Addr2 = regaddr_t'(NREG - 1 - i);
            #1;
            check({tag, "_p1"}, Rd_data1, 32'h0);
            check({tag, "_p2"}, Rd_data2, 32'h0);
        end
    endtask

    initial begin
        tick();
        tick();
        read_all_zero("rst");
        check("rst_cnt", Retire_cnt, 32'h0);
        RSTN = 1'b1;

        RegWrite_in = 1'b1; Write_Addr_in = 5'd5; Result_in = 32'h1234_5678;
        Read_data_in = 32'h5555_5555;
        #1 check("wb_result", WB_value, 32'h1234_5678);
        tick();
        RegWrite_in = 1'b0; Rd_Addr1 = 5'd5;
        #1 check("commit_r5", Rd_data1, 32'h1234_5678);
        check("commit_cnt", Retire_cnt, 32'd1);

        RegWrite_in = 1'b1; MemtoReg_in = 1'b1; Write_Addr_in = 5'd9;
        Read_data_in = 32'hDEAD_BEEF; Result_in = 32'h1111_1111;
        Rd_Addr1 = 5'd9; Rd_Addr2 = 5'd9;
        #1 check("byp_p1", Rd_data1, 32'hDEAD_BEEF);
        check("byp_p2", Rd_data2, 32'hDEAD_BEEF);
        check("byp_wb", WB_value, 32'hDEAD_BEEF);
        tick();
        RegWrite_in = 1'b0; MemtoReg_in = 1'b0;
        #1 check("store_r9", Rd_data1, 32'hDEAD_BEEF);
        check("store_cnt", Retire_cnt, 32'd2);

        Write_Addr_in = 5'd3; Result_in = 32'hFFFF_FFFF; Rd_Addr1 = 5'd3;
        #1 check("nowr_pre", Rd_data1, 32'h0);
        check("nowr_wb", WB_value, 32'hFFFF_FFFF);
        tick();
        check("nowr_post", Rd_data1, 32'h0);
        check("nowr_cnt", Retire_cnt, 32'd2);

        RegWrite_in = 1'b1; Write_Addr_in = 5'd0; Result_in = 32'hA;
        Rd_Addr1 = 5'd0; Rd_Addr2 = 5'd5;
        #1 check("r0_a_byp", Rd_data1, 32'hA);
        check("r0_p2_indep", Rd_data2, 32'h1234_5678);
        tick();
        check("r0_a_store", dut.u_core.regs[0], 32'hA);
        Result_in = 32'hB;
        #1 check("r0_b_byp", Rd_data1, 32'hB);
        tick();
        RegWrite_in = 1'b0;
        #1 check("r0_b_store", Rd_data1, 32'hB);
        check("r0_cnt", Retire_cnt, 32'd4);

        force dut.Retire_cnt = 32'hFFFF_FFFF;
        #1 release dut.Retire_cnt;
        #1 check("wrap_pre", Retire_cnt, 32'hFFFF_FFFF);
        RegWrite_in = 1'b1; Write_Addr_in = 5'd7; Result_in = 32'h77;
        tick();
        RegWrite_in = 1'b0; Rd_Addr1 = 5'd7;
        #1 check("wrap_cnt", Retire_cnt, 32'h0);
        check("wrap_r7", Rd_data1, 32'h77);
        tick();
        check("wrap_hold", Retire_cnt, 32'h0);

        RegWrite_in = 1'b1; Write_Addr_in = 5'd8; Result_in = 32'h88;
        tick();
        RegWrite_in = 1'b0;
        #1 check("pre_rst_cnt", Retire_cnt, 32'd1);
        RSTN = 1'b0;
        #1 read_all_zero("mid_rst");
        check("mid_rst_cnt", Retire_cnt, 32'h0);
        RegWrite_in = 1'b1; Write_Addr_in = 5'd5; Result_in = 32'hCAFE_F00D;
        tick();
        RegWrite_in = 1'b0; RSTN = 1'b1; Rd_Addr1 = 5'd5;
        tick();
        check("rst_edge_lost", Rd_data1, 32'h0);
        check("rst_edge_cnt", Retire_cnt, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
